// File: rtl/axis_frame_checker_pkg.sv
// rtl/axis_frame_checker_pkg.sv - shared constants, FSM encoding and LFSR step for the frame checker
package axis_frame_checker_pkg;

    localparam logic [31:0] EXPECT_DATA_DEFAULT = 32'h00FF00FF;
    localparam logic [7:0]  LFSR_SEED           = 8'hA5;
    // x^8+x^6+x^5+x^4+1 expressed as the register bits feeding the XOR
    localparam logic [7:0]  LFSR_TAPS           = 8'hB8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RECV   = 2'd1,
        ST_RESYNC = 2'd2
    } fc_state_t;

    function automatic logic [7:0] lfsr_step(input logic [7:0] cur);
        return {cur[6:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/axis_lfsr_throttle.sv
// rtl/axis_lfsr_throttle.sv - pseudo-random ready throttle, stalls roughly one cycle in four
module axis_lfsr_throttle
    import axis_frame_checker_pkg::*;
(
    input  logic clk,
    input  logic rstn,
    output logic ready_o
);

    logic [7:0] lfsr;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= lfsr_step(lfsr);
        end
    end

    assign ready_o = (lfsr[1:0] != 2'b00);

endmodule

// File: rtl/axis_frame_checker.sv
// rtl/axis_frame_checker.sv - AXI-Stream sink checking fixed-length frames, with statistics
// Optional AXIS_BACKPRESSURE_EN throttles tready through axis_lfsr_throttle.
module axis_frame_checker
    import axis_frame_checker_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    LENGTH      = 32,
    parameter logic [DATA_WIDTH-1:0] EXPECT_DATA = DATA_WIDTH'(EXPECT_DATA_DEFAULT),
    parameter int                    ERR_W       = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [DATA_WIDTH-1:0] tdata,
    input  logic                  tlast,
    input  logic                  tvalid,
    output logic                  tready,
    input  logic                  clr_stats,
    output logic [31:0]           frame_cnt,
    output logic [ERR_W-1:0]      err_cnt,
    output logic                  data_err,
    output logic                  len_err,
    output logic                  frame_done
);

    localparam int               IDX_W    = (LENGTH > 1) ? $clog2(LENGTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LENGTH - 1);

    fc_state_t        state, state_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic             frame_bad, frame_bad_nxt;
    logic             end_pend, end_pend_nxt;
    logic             end_good, end_good_nxt;
    logic             data_err_nxt, len_err_nxt;
    logic [31:0]      frame_cnt_nxt;
    logic [ERR_W-1:0] err_cnt_nxt;
    logic             bad_now;
    logic             ready_run;
    logic             beat;

`ifdef AXIS_BACKPRESSURE_EN
    logic throttle_ready;

    axis_lfsr_throttle u_throttle (
        .clk     (clk),
        .rstn    (rstn),
        .ready_o (throttle_ready)
    );

    assign tready = ready_run & throttle_ready;
`else
    assign tready = ready_run;
`endif

    assign beat = tvalid & tready;

    always_comb begin
        state_nxt     = state;
        idx_nxt       = idx;
        // the previous frame's verdict is already latched in end_good, so start the new one clean
        frame_bad_nxt = end_pend ? 1'b0 : frame_bad;
        end_pend_nxt  = 1'b0;
        end_good_nxt  = 1'b0;
        data_err_nxt  = data_err;
        len_err_nxt   = len_err;
        frame_cnt_nxt = frame_cnt;
        err_cnt_nxt   = err_cnt;
        bad_now       = 1'b0;

        if (end_pend) begin
            if (end_good) begin
                frame_cnt_nxt = frame_cnt + 32'd1;
            end else if (err_cnt != '1) begin
                err_cnt_nxt = err_cnt + 1'b1;
            end
        end

        if (beat) begin
            case (state)
                ST_IDLE, ST_RECV: begin
                    if (tdata != EXPECT_DATA) begin
                        data_err_nxt = 1'b1;
                    end
                    bad_now       = frame_bad_nxt | (tdata != EXPECT_DATA);
                    frame_bad_nxt = bad_now;
                    if (idx != LAST_IDX) begin
                        if (tlast) begin
                            len_err_nxt  = 1'b1;
                            end_pend_nxt = 1'b1;
                            idx_nxt      = '0;
                            state_nxt    = ST_IDLE;
                        end else begin
                            idx_nxt   = idx + 1'b1;
                            state_nxt = ST_RECV;
                        end
                    end else begin
                        idx_nxt      = '0;
                        end_pend_nxt = 1'b1;
                        if (tlast) begin
                            end_good_nxt = ~bad_now;
                            state_nxt    = ST_IDLE;
                        end else begin
                            len_err_nxt = 1'b1;
                            state_nxt   = ST_RESYNC;
                        end
                    end
                end
                ST_RESYNC: begin
                    if (tlast) begin
                        idx_nxt   = '0;
                        state_nxt = ST_IDLE;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end

        if (clr_stats) begin
            frame_cnt_nxt = '0;
            err_cnt_nxt   = '0;
            data_err_nxt  = 1'b0;
            len_err_nxt   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= ST_IDLE;
            idx        <= '0;
            frame_bad  <= 1'b0;
            end_pend   <= 1'b0;
            end_good   <= 1'b0;
            frame_cnt  <= '0;
            err_cnt    <= '0;
            data_err   <= 1'b0;
            len_err    <= 1'b0;
            frame_done <= 1'b0;
            ready_run  <= 1'b0;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            frame_bad  <= frame_bad_nxt;
            end_pend   <= end_pend_nxt;
            end_good   <= end_good_nxt;
            frame_cnt  <= frame_cnt_nxt;
            err_cnt    <= err_cnt_nxt;
            data_err   <= data_err_nxt;
            len_err    <= len_err_nxt;
            frame_done <= end_pend;
            ready_run  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_axis_frame_checker.sv
// tb/tb_axis_frame_checker.sv - self-checking bench for axis_frame_checker
module tb_axis_frame_checker;

    localparam int          LEN = 32;
    localparam logic [31:0] EXP = 32'h00FF00FF;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] tdata = '0;
    logic        tlast = 1'b0;
    logic        tvalid = 1'b0;
    logic        tready;
    logic        clr_stats = 1'b0;
    logic [31:0] frame_cnt;
    logic [15:0] err_cnt;
    logic        data_err;
    logic        len_err;
    logic        frame_done;

    always #5 clk = ~clk;

    axis_frame_checker dut (
        .clk        (clk),
        .rstn       (rstn),
        .tdata      (tdata),
        .tlast      (tlast),
        .tvalid     (tvalid),
        .tready     (tready),
        .clr_stats  (clr_stats),
        .frame_cnt  (frame_cnt),
        .err_cnt    (err_cnt),
        .data_err   (data_err),
        .len_err    (len_err),
        .frame_done (frame_done)
    );

    int   total = 0;
    int   bad = 0;
    bit   sb_q[$];
    bit   sb_g;
    int   exp_fc = 0;
    int   exp_ec = 0;
    bit   clr_at_done = 0;

    typedef struct {
        string name;
        int    nf;
        int    tl0, bb0, tl1, bb1, tl2, bb2;
        int    fc, ec;
        bit    de, le;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // frame end -> pop expected verdict, advance model counters, compare
    always @(negedge clk) begin
        if (rstn && frame_done) begin
            if (sb_q.size() == 0) begin
                check("frame_done_unexpected", frame_done, 0);
            end else begin
                sb_g = sb_q.pop_front();
                if (clr_at_done) begin
                    exp_fc = 0;
                    exp_ec = 0;
                    clr_at_done = 0;
                end else if (sb_g) begin
                    exp_fc++;
                end else if (exp_ec < 65535) begin
                    exp_ec++;
                end
                check("frame_cnt_at_done", frame_cnt, exp_fc);
                check("err_cnt_at_done", {16'd0, err_cnt}, exp_ec);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input logic [31:0] d, input logic l);
        int   n = 0;
        logic acc;
        tdata  = d;
        tlast  = l;
        tvalid = 1'b1;
        do begin
            acc = tready;
            tick();
            n++;
        end while (!acc && n < 200);
        if (!acc) check("beat_timeout", acc, 1);
    endtask

    task automatic send_frame(input int tl, input int bb);
        sb_q.push_back(tl == LEN - 1 && bb < 0);
        for (int i = 0; i <= tl; i++) begin
            drive_beat((i == bb) ? (EXP ^ 32'h1) : EXP, i == tl);
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic clear_stats();
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        exp_fc = 0;
        exp_ec = 0;
        check("clr.frame_cnt", frame_cnt, 0);
        check("clr.err_cnt", {16'd0, err_cnt}, 0);
        check("clr.flags", {data_err, len_err}, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".tready"}, tready, 0);
        check({tag, ".frame_cnt"}, frame_cnt, 0);
        check({tag, ".err_cnt"}, {16'd0, err_cnt}, 0);
        check({tag, ".flags"}, {data_err, len_err, frame_done}, 0);
    endtask

    logic [7:0] m;

    initial begin
        vecs[0] = '{"clean3",           3, 31, -1, 31, -1, 31, -1, 3, 0, 1'b0, 1'b0};
        vecs[1] = '{"bad_beat5",        3, 31, -1, 31,  5, 31, -1, 2, 1, 1'b1, 1'b0};
        vecs[2] = '{"short15",          2, 15, -1, 31, -1,  0,  0, 1, 1, 1'b0, 1'b1};
        vecs[3] = '{"long40",           2, 40, -1, 31, -1,  0,  0, 1, 1, 1'b0, 1'b1};
        vecs[4] = '{"long_discard_bad", 2, 40, 35, 31, -1,  0,  0, 1, 1, 1'b0, 1'b1};
        vecs[5] = '{"bad_last_beat",    2, 31, 31, 31, -1,  0,  0, 1, 1, 1'b1, 1'b0};
        vecs[6] = '{"bad_first_beat",   2, 31, -1, 31,  0,  0,  0, 1, 1, 1'b1, 1'b0};

        repeat (3) tick();
        check_all_zero("reset");
        rstn = 1'b1;
        tick();

        for (int c = 0; c < 7; c++) begin
            clear_stats();
            if (vecs[c].nf > 0) send_frame(vecs[c].tl0, vecs[c].bb0);
            if (vecs[c].nf > 1) send_frame(vecs[c].tl1, vecs[c].bb1);
            if (vecs[c].nf > 2) send_frame(vecs[c].tl2, vecs[c].bb2);
            repeat (4) tick();
            check({vecs[c].name, ".frame_cnt"}, frame_cnt, vecs[c].fc);
            check({vecs[c].name, ".err_cnt"}, {16'd0, err_cnt}, vecs[c].ec);
            check({vecs[c].name, ".data_err"}, data_err, vecs[c].de);
            check({vecs[c].name, ".len_err"}, len_err, vecs[c].le);
            check({vecs[c].name, ".pending"}, sb_q.size(), 0);
        end

        // clr_stats lands on the counter-update edge of a good frame
        clear_stats();
        sb_q.push_back(1'b1);
        for (int i = 0; i < LEN - 1; i++) drive_beat(EXP, 1'b0);
        drive_beat(EXP, 1'b1);
        tvalid = 1'b0;
        tlast  = 1'b0;
        check("clr_race.done_early", frame_done, 0);
        clr_stats   = 1'b1;
        clr_at_done = 1'b1;
        tick();
        clr_stats = 1'b0;
        check("clr_race.frame_done", frame_done, 1);
        check("clr_race.frame_cnt", frame_cnt, 0);
        tick();
        check("clr_race.done_one_cycle", frame_done, 0);
        check("clr_race.pending", sb_q.size(), 0);

        // reset in the middle of a frame after stats became nonzero
        send_frame(15, -1);
        for (int i = 0; i < 10; i++) drive_beat(EXP, 1'b0);
        rstn = 1'b0;
        repeat (2) begin
            tick();
            check_all_zero("midreset");
        end
        exp_fc = 0;
        exp_ec = 0;
        tvalid = 1'b0;
        rstn   = 1'b1;
`ifdef AXIS_BACKPRESSURE_EN
        m = 8'hA5;
        for (int k = 0; k < 12; k++) begin
            tick();
            m = {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]};
            check("lfsr_tready", tready, m[1:0] != 2'b00);
        end
`else
        m = 8'h00;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("tready_after_reset", tready, 1);
        end
`endif
        send_frame(31, -1);
        repeat (4) tick();
        check("post_reset.frame_cnt", frame_cnt, 1);
        check("post_reset.err_cnt", {16'd0, err_cnt}, 0);
        check("post_reset.flags", {data_err, len_err}, 0);
        check("post_reset.pending", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
